io_uart_in: RTL and testbench

//  Receive-side companion to io_uart_out on the IO bus. Buffers characters from uart_top's RX path
//  (CPU run mode) in a FIFO for the CPU to pop via memory-mapped IO reads, and raises a

---
 rtl/io_uart_in_pkg.sv | 31 +++
 rtl/io_uart_in_sync_fifo_rx.sv | 66 ++++++
 rtl/io_uart_in.sv | 108 ++++++++++
 tb/tb_io_uart_in.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_in_pkg.sv
// IO map for the UART receive block: word addresses and register bit positions,
// shared with firmware headers and the io_uart_out address checks.
package io_uart_in_pkg;

    localparam logic [13:0] IO_ADR_RXDATA = 14'h3F04;   // byte 0xFC10
    localparam logic [13:0] IO_ADR_RXSTAT = 14'h3F05;   // byte 0xFC14
    localparam logic [13:0] IO_ADR_RXCTRL = 14'h3F06;   // byte 0xFC18

    localparam int STAT_NEMPTY  = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_OVR_CLR = 1;
    localparam int CTRL_FLUSH   = 2;

    localparam int RXDATA_VALID = 8;

    function automatic logic [31:0] rxstat_word(input logic [7:0] cnt, input logic ovr,
                                                input logic full, input logic nempty);
        logic [31:0] word;
        word = '0;
        word[STAT_CNT_LSB +: 8] = cnt;
        word[STAT_OVR]          = ovr;
        word[STAT_FULL]         = full;
        word[STAT_NEMPTY]       = nempty;
        return word;
    endfunction

endpackage

// File: rtl/io_uart_in_sync_fifo_rx.sv
// Receive character FIFO: push/pop/flush with combinational head and occupancy count.
module sync_fifo_rx #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_next,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a full FIFO needs; a flush discards the push
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_comb begin
        o_count_next = r_count;
        if (i_flush)
            o_count_next = '0;
        else if (w_do_push & ~w_do_pop)
            o_count_next = r_count + 1'b1;
        else if (~w_do_push & w_do_pop)
            o_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= o_count_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/io_uart_in.sv
// UART receive buffer on the IO bus: FIFO of RX characters popped by CPU reads,
// status/control registers, level interrupt, and a slot in the read-data daisy chain.
module io_uart_in
    import io_uart_in_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [13:0] ADR_DATA   = IO_ADR_RXDATA,
    parameter logic [13:0] ADR_STAT   = IO_ADR_RXSTAT,
    parameter logic [13:0] ADR_CTRL   = IO_ADR_RXCTRL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    input  logic [7:0]  uart_rx_char,
    input  logic        uart_rx_we,
    output logic        uart_rx_irq
);
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;
    logic [DEPTH_LOG2:0] w_count_next;
    logic                w_full;
    logic                w_empty;
    logic                w_rd_data;
    logic                w_rd_stat;
    logic                w_rd_ctrl;
    logic                w_ctrl_wr;
    logic                w_pop;
    logic                w_flush;
    logic                w_overrun_set;
    logic                w_irq_en_next;
    logic [31:0]         w_rd_value;
    logic                w_unused;

    logic                r_irq_en;
    logic                r_overrun;
    logic                r_hit;
    logic [31:0]         r_rdata;
    logic                r_irq;

    assign w_rd_data     = dma_io_radr_en & (dma_io_radr == ADR_DATA);
    assign w_rd_stat     = dma_io_radr_en & (dma_io_radr == ADR_STAT);
    assign w_rd_ctrl     = dma_io_radr_en & (dma_io_radr == ADR_CTRL);
    assign w_ctrl_wr     = dma_io_we & (dma_io_wadr == ADR_CTRL);
    assign w_pop         = w_rd_data & ~w_empty;
    assign w_flush       = w_ctrl_wr & dma_io_wdata[CTRL_FLUSH];
    assign w_overrun_set = uart_rx_we & w_full & ~w_pop & ~w_flush;
    assign w_irq_en_next = w_ctrl_wr ? dma_io_wdata[CTRL_IRQ_EN] : r_irq_en;
    assign w_unused      = &{1'b0, dma_io_wdata[31:3]};

    sync_fifo_rx #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (uart_rx_we),
        .i_din        (uart_rx_char),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_comb begin
        w_rd_value = '0;
        if (w_rd_data && !w_empty) begin
            w_rd_value[7:0]          = w_head;
            w_rd_value[RXDATA_VALID] = 1'b1;
        end else if (w_rd_stat) begin
            w_rd_value = rxstat_word(8'(w_count), r_overrun, w_full, ~w_empty);
        end else if (w_rd_ctrl) begin
            w_rd_value[CTRL_IRQ_EN] = r_irq_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en  <= 1'b0;
            r_overrun <= 1'b0;
            r_hit     <= 1'b0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_next;
            // A new overrun in the clear cycle must not be lost
            if (w_overrun_set)
                r_overrun <= 1'b1;
            else if (w_ctrl_wr && dma_io_wdata[CTRL_OVR_CLR])
                r_overrun <= 1'b0;
            r_hit   <= w_rd_data | w_rd_stat | w_rd_ctrl;
            r_rdata <= w_rd_value;
            r_irq   <= w_irq_en_next & (w_count_next != '0);
        end
    end

    assign dma_io_rdata = r_hit ? r_rdata : dma_io_rdata_in;
    assign uart_rx_irq  = r_irq;

endmodule

// File: tb/tb_io_uart_in.sv
// Scoreboard bench for io_uart_in: a small FIFO/register model predicts every IO read.
module tb_io_uart_in;
    import io_uart_in_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic [7:0]  uart_rx_char;
    logic        uart_rx_we;
    logic        uart_rx_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_q[$];
    logic        m_ovr;
    logic        m_ien;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    io_uart_in dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .uart_rx_char    (uart_rx_char),
        .uart_rx_we      (uart_rx_we),
        .uart_rx_irq     (uart_rx_irq)
    );

    function automatic void model_push(input logic [7:0] c);
        if (m_q.size() < 16) m_q.push_back(c);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == IO_ADR_RXDATA) begin
            if (m_q.size() != 0) v = {23'd0, 1'b1, m_q.pop_front()};
        end else if (a == IO_ADR_RXSTAT) begin
            v = {16'd0, 8'(m_q.size()), 5'd0, m_ovr, (m_q.size() == 16), (m_q.size() != 0)};
        end else if (a == IO_ADR_RXCTRL) begin
            v = {31'd0, m_ien};
        end else begin
            v = dma_io_rdata_in;
        end
        return v;
    endfunction

    task automatic io_read(input logic [13:0] a, output logic [31:0] obs);
        sb.push_back(model_read(a));
        dma_io_radr    = a;
        dma_io_radr_en = 1'b1;
        @(negedge clk);
        dma_io_radr_en = 1'b0;
        obs = dma_io_rdata;
    endtask

    task automatic io_write(input logic [13:0] a, input logic [31:0] d);
        dma_io_wadr  = a;
        dma_io_wdata = d;
        dma_io_we    = 1'b1;
        @(negedge clk);
        dma_io_we = 1'b0;
        if (a == IO_ADR_RXCTRL) begin
            m_ien = d[0];
            if (d[1]) m_ovr = 1'b0;
            if (d[2]) m_q.delete();
        end
    endtask

    task automatic push_char(input logic [7:0] c);
        uart_rx_char = c;
        uart_rx_we   = 1'b1;
        @(negedge clk);
        uart_rx_we = 1'b0;
        model_push(c);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr = 1'b0;
        m_ien = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dma_io_rdata_in = 32'hCAFE_0001;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dma_io_rdata !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL reset_chain got %h want %h", dma_io_rdata, 32'hCAFE_0001);
        end
        checks++;
        if (uart_rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", uart_rx_irq);
        end
        rst_n = 1'b1;
        dma_io_rdata_in = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] obs, exp;
        push_char(8'h41);
        push_char(8'h42);
        for (int i = 0; i < 3; i++) begin
            io_read(IO_ADR_RXDATA, obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic_rxdata%0d got %h want %h", i, obs, exp);
            end
        end
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL basic_rxstat got %h want %h", obs, exp);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] obs, exp;
        for (int i = 1; i <= 17; i++) push_char(8'(i));
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ovr_stat got %h want %h", obs, exp);
        end
        // clear and a fresh overrun land on the same edge
        uart_rx_char = 8'h18;
        uart_rx_we   = 1'b1;
        io_write(IO_ADR_RXCTRL, 32'h2);
        uart_rx_we = 1'b0;
        m_ovr = 1'b1;
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ovr_clr_race got %h want %h", obs, exp);
        end
        for (int i = 0; i < 16; i++) begin
            io_read(IO_ADR_RXDATA, obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ovr_pop%0d got %h want %h", i, obs, exp);
            end
        end
        io_write(IO_ADR_RXCTRL, 32'h2);
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ovr_cleared got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs, exp;
        for (int i = 0; i < 16; i++) push_char(8'h20 + 8'(i));
        uart_rx_char = 8'h99;
        uart_rx_we   = 1'b1;
        io_read(IO_ADR_RXDATA, obs);
        uart_rx_we = 1'b0;
        model_push(8'h99);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_pop got %h want %h", obs, exp);
        end
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_stat got %h want %h", obs, exp);
        end
        for (int i = 0; i < 16; i++) begin
            io_read(IO_ADR_RXDATA, obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_drain%0d got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] obs, exp;
        io_write(IO_ADR_RXCTRL, 32'h1);
        checks++;
        if (uart_rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_empty got %b want 0", uart_rx_irq);
        end
        push_char(8'h55);
        checks++;
        if (uart_rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_push got %b want 1", uart_rx_irq);
        end
        io_read(IO_ADR_RXDATA, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL irq_data got %h want %h", obs, exp);
        end
        checks++;
        if (uart_rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_pop got %b want 0", uart_rx_irq);
        end
        io_write(IO_ADR_RXCTRL, 32'h0);
        push_char(8'h66);
        checks++;
        if (uart_rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked got %b want 0", uart_rx_irq);
        end
        io_write(IO_ADR_RXCTRL, 32'h1);
        checks++;
        if (uart_rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_enable got %b want 1", uart_rx_irq);
        end
        io_read(IO_ADR_RXCTRL, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL irq_ctrl_rd got %h want %h", obs, exp);
        end
        io_read(IO_ADR_RXDATA, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL irq_data2 got %h want %h", obs, exp);
        end
        io_write(IO_ADR_RXCTRL, 32'h0);
    endtask

    task automatic test_chain();
        logic [31:0] obs, exp;
        push_char(8'h77);
        dma_io_rdata_in = 32'hDEAD_BEEF;
        io_read(14'h3F07, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL chain_pass got %h want %h", obs, exp);
        end
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL chain_nopop got %h want %h", obs, exp);
        end
        io_read(IO_ADR_RXDATA, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL chain_data got %h want %h", obs, exp);
        end
        dma_io_rdata_in = 32'h0;
    endtask

    task automatic test_reset_flush();
        logic [31:0] obs, exp;
        push_char(8'hA1);
        push_char(8'hA2);
        push_char(8'hA3);
        io_write(IO_ADR_RXCTRL, 32'h1);
        dma_io_rdata_in = 32'h1234_5678;
        dma_io_radr     = IO_ADR_RXDATA;
        dma_io_radr_en  = 1'b1;
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        dma_io_radr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (dma_io_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rst_inflight got %h want %h", dma_io_rdata, 32'h1234_5678);
        end
        checks++;
        if (uart_rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_irq got %b want 0", uart_rx_irq);
        end
        rst_n = 1'b1;
        dma_io_rdata_in = 32'h0;
        model_reset();
        @(negedge clk);
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rst_stat got %h want %h", obs, exp);
        end
        push_char(8'hB1);
        push_char(8'hB2);
        push_char(8'hB3);
        io_write(IO_ADR_RXCTRL, 32'h4);
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_stat got %h want %h", obs, exp);
        end
        // flush and push on one edge: char discarded, no overrun
        push_char(8'hC1);
        uart_rx_char = 8'h88;
        uart_rx_we   = 1'b1;
        io_write(IO_ADR_RXCTRL, 32'h4);
        uart_rx_we = 1'b0;
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_push got %h want %h", obs, exp);
        end
        // flush and pop on one edge: head returned, then empty
        push_char(8'h31);
        push_char(8'h32);
        sb.push_back(model_read(IO_ADR_RXDATA));
        dma_io_radr    = IO_ADR_RXDATA;
        dma_io_radr_en = 1'b1;
        io_write(IO_ADR_RXCTRL, 32'h4);
        dma_io_radr_en = 1'b0;
        obs = dma_io_rdata;
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_pop got %h want %h", obs, exp);
        end
        io_read(IO_ADR_RXSTAT, obs);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_pop_stat got %h want %h", obs, exp);
        end
    endtask

    initial begin
        dma_io_we      = 1'b0;
        dma_io_wadr    = '0;
        dma_io_wdata   = '0;
        dma_io_radr    = '0;
        dma_io_radr_en = 1'b0;
        uart_rx_char   = '0;
        uart_rx_we     = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_irq();
        test_chain();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
